// File: rtl/q_action_select.sv
// Epsilon-greedy action selector for a grid-world Q-learning agent.
// Reads the Q-values for the current cell, picks an action and presents the step downstream.
module q_action_select #(
  parameter int ROWS        = 5,
  parameter int COLS        = 5,
  parameter int ACTIONS     = 4,
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int GOAL_ROW    = 4,
  parameter int GOAL_COL    = 4,
  parameter int GOAL_REWARD = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            eps_thresh,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [2:0]            row,
  output logic [2:0]            col,
  output logic [1:0]            action,
  output logic [2:0]            next_row,
  output logic [2:0]            next_col,
  output logic [7:0]            reward,
  output logic                  step_valid,
  input  logic                  step_ready,
  output logic                  episode_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_SELECT,
    S_OUT
  } state_t;

  localparam logic [1:0] LAST_A   = 2'(ACTIONS - 1);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);
  localparam logic [2:0] G_ROW    = 3'(GOAL_ROW);
  localparam logic [2:0] G_COL    = 3'(GOAL_COL);

  state_t                  state;
  state_t                  state_next;
  logic [1:0]              a_cnt;
  logic                    rd_pending;
  logic [1:0]              rd_idx;
  logic [DATA_WIDTH-1:0]   max_val;
  logic [1:0]              max_act;
  logic [15:0]             lfsr;
  logic                    lfsr_fb;
  logic [ADDR_WIDTH-1:0]   cell_base;
  logic                    explore;
  logic [1:0]              sel_act;
  logic [2:0]              sel_row;
  logic [2:0]              sel_col;
  logic                    next_is_goal;

  assign lfsr_fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cell_base    = ADDR_WIDTH'((32'(row) * 32'(COLS) + 32'(col)) * 32'(ACTIONS));
  assign next_is_goal = (next_row == G_ROW) && (next_col == G_COL);

  // Action choice and the clamped move it implies; latched on leaving SELECT.
  always_comb begin
    explore = lfsr[7:0] < eps_thresh;
    sel_act = explore ? lfsr[9:8] : max_act;
    sel_row = row;
    sel_col = col;
    case (sel_act)
      2'd0: if (row != 3'd0)    sel_row = row - 3'd1;
      2'd1: if (row != LAST_ROW) sel_row = row + 3'd1;
      2'd2: if (col != 3'd0)    sel_col = col - 3'd1;
      default: if (col != LAST_COL) sel_col = col + 3'd1;
    endcase
  end

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    rd_addr    = '0;
    step_valid = 1'b0;
    case (state)
      S_IDLE:   if (start) state_next = S_READ;
      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = cell_base + ADDR_WIDTH'(a_cnt);
        if (a_cnt == LAST_A) state_next = S_DRAIN;
      end
      S_DRAIN:  state_next = S_SELECT;
      S_SELECT: state_next = S_OUT;
      S_OUT: begin
        step_valid = 1'b1;
        if (step_ready) state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      a_cnt        <= '0;
      rd_pending   <= 1'b0;
      rd_idx       <= '0;
      max_val      <= '0;
      max_act      <= '0;
      lfsr         <= 16'hACE1;
      row          <= '0;
      col          <= '0;
      action       <= '0;
      next_row     <= '0;
      next_col     <= '0;
      reward       <= '0;
      episode_done <= 1'b0;
    end else begin
      state      <= state_next;
      lfsr       <= {lfsr[14:0], lfsr_fb};
      a_cnt      <= (state == S_READ) ? a_cnt + 2'd1 : 2'd0;
      rd_pending <= rd_en;
      rd_idx     <= a_cnt;

      // Data for a read arrives one cycle late; strict compare keeps the lowest index on ties.
      if (rd_pending && (rd_idx == 2'd0 || rd_data > max_val)) begin
        max_val <= rd_data;
        max_act <= rd_idx;
      end

      if (state == S_SELECT) begin
        action   <= sel_act;
        next_row <= sel_row;
        next_col <= sel_col;
        reward   <= ((sel_row == G_ROW) && (sel_col == G_COL)) ? 8'(GOAL_REWARD) : 8'd0;
      end

      episode_done <= 1'b0;
      if (state == S_OUT && step_ready) begin
        if (next_is_goal) begin
          row          <= '0;
          col          <= '0;
          episode_done <= 1'b1;
        end else begin
          row <= next_row;
          col <= next_col;
        end
      end
    end
  end

endmodule

// File: tb/tb_q_action_select.sv
// Directed bench for q_action_select: Q-table memory model, LFSR model and grid position model.
module tb_q_action_select;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] eps_thresh;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [2:0] row, col, next_row, next_col;
  logic [1:0] action;
  logic [7:0] reward;
  logic       step_valid;
  logic       step_ready;
  logic       episode_done;

  int total = 0;
  int bad   = 0;

  logic [7:0]  q [0:127];
  logic [15:0] m_lfsr;
  logic [15:0] snap;
  logic [2:0]  mr, mc;

  q_action_select #(
    .ROWS(5), .COLS(5), .ACTIONS(4), .ADDR_WIDTH(7), .DATA_WIDTH(8),
    .GOAL_ROW(4), .GOAL_COL(4), .GOAL_REWARD(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .eps_thresh(eps_thresh),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .row(row), .col(col), .action(action),
    .next_row(next_row), .next_col(next_col), .reward(reward),
    .step_valid(step_valid), .step_ready(step_ready), .episode_done(episode_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rd_en ? q[rd_addr] : 8'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < 128; i++) q[i] = 8'd0;
  endtask

  // One complete agent step; greedy is the hand-derived argmax for the current cell.
  task automatic run_step(input int hold, input logic [1:0] greedy);
    logic [6:0] base;
    logic [1:0] ea;
    logic [2:0] nr, nc;
    logic [7:0] er;
    logic       goal;
    base = 7'((32'(mr) * 5 + 32'(mc)) * 4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rd_en_a0", 32'(rd_en), 1);
    chk("rd_addr_a0", 32'(rd_addr), 32'(base));
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rd_addr_ak", 32'(rd_addr), 32'(base) + 32'(k));
    end
    @(posedge clk); #1;
    chk("rd_en_drain", 32'(rd_en), 0);
    @(posedge clk); #1;
    snap = m_lfsr;
    chk("valid_early", 32'(step_valid), 0);
    @(posedge clk); #1;
    ea = (snap[7:0] < eps_thresh) ? snap[9:8] : greedy;
    nr = mr; nc = mc;
    case (ea)
      2'd0: if (mr != 3'd0) nr = mr - 3'd1;
      2'd1: if (mr != 3'd4) nr = mr + 3'd1;
      2'd2: if (mc != 3'd0) nc = mc - 3'd1;
      default: if (mc != 3'd4) nc = mc + 3'd1;
    endcase
    goal = (nr == 3'd4) && (nc == 3'd4);
    er = goal ? 8'd10 : 8'd0;
    chk("step_valid", 32'(step_valid), 1);
    chk("action", 32'(action), 32'(ea));
    chk("next_row", 32'(next_row), 32'(nr));
    chk("next_col", 32'(next_col), 32'(nc));
    chk("reward", 32'(reward), 32'(er));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(step_valid), 1);
      chk("hold_action", 32'(action), 32'(ea));
      chk("hold_next", 32'({next_row, next_col}), 32'({nr, nc}));
      chk("hold_reward", 32'(reward), 32'(er));
      chk("hold_pos", 32'({row, col}), 32'({mr, mc}));
    end
    step_ready = 1'b1;
    @(posedge clk); #1;
    step_ready = 1'b0;
    if (goal) begin
      mr = 3'd0; mc = 3'd0;
    end else begin
      mr = nr; mc = nc;
    end
    chk("valid_after_acc", 32'(step_valid), 0);
    chk("episode_done", 32'(episode_done), 32'(goal));
    chk("pos_after_acc", 32'({row, col}), 32'({mr, mc}));
    @(posedge clk); #1;
    chk("episode_done_clr", 32'(episode_done), 0);
    chk("pos_idle", 32'({row, col}), 32'({mr, mc}));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; eps_thresh = 8'd0; step_ready = 1'b0;
    mr = 3'd0; mc = 3'd0; snap = 16'd0;
    clear_q();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_valid", 32'(step_valid), 0);
    chk("rst_done", 32'(episode_done), 0);
    chk("rst_pos", 32'({row, col}), 0);
    chk("rst_outs", 32'({action, next_row, next_col, reward}), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    @(negedge clk); rst = 1'b0;
    #1;

    // all Q zero at origin: greedy up, wall keeps the agent in place
    run_step(0, 2'd0);
    // Q[3]=5 at origin: move right
    q[3] = 8'd5;
    run_step(0, 2'd3);
    // walk down the column with backpressure on the first move
    q[(0 * 5 + 1) * 4 + 1] = 8'd5;
    run_step(3, 2'd1);
    for (int r = 1; r < 4; r++) begin
      q[(r * 5 + 1) * 4 + 1] = 8'd5;
      run_step(0, 2'd1);
    end
    q[87] = 8'd5;
    run_step(0, 2'd3);
    q[91] = 8'd5;
    run_step(0, 2'd3);
    chk("at_4_3", 32'({row, col}), 32'({3'd4, 3'd3}));
    // tie with higher index must not win; Q[95]=9 is the strict max
    q[92] = 8'd9; q[95] = 8'd9; q[92] = 8'd1;
    q[93] = 8'd9; q[93] = 8'd0;
    run_step(0, 2'd3);

    // ties across all actions resolve to action 0
    clear_q();
    q[0] = 8'd7; q[1] = 8'd7; q[2] = 8'd7; q[3] = 8'd7;
    run_step(0, 2'd0);
    q[2] = 8'd8; q[3] = 8'd8;
    run_step(0, 2'd2);

    // exploration with Q all zero: greedy fallback is action 0
    clear_q();
    eps_thresh = 8'd255;
    for (int s = 0; s < 64; s++) run_step(0, 2'd0);

    // reset while reading aborts the step
    eps_thresh = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mid_rd_en", 32'(rd_en), 1);
    rst = 1'b1;
    #1;
    chk("abort_rd_en", 32'(rd_en), 0);
    chk("abort_valid", 32'(step_valid), 0);
    chk("abort_pos", 32'({row, col}), 0);
    chk("abort_addr", 32'(rd_addr), 0);
    @(negedge clk); rst = 1'b0;
    mr = 3'd0; mc = 3'd0;
    #1;
    run_step(0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
